// File: rtl/clint_timer_if.sv
// Request/response bus of the core-local interruptor: single outstanding request,
// initiator holds the fields until the one-cycle bus_ready strobe.
interface clint_timer_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_write;
    logic        bus_valid;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_addr, bus_wdata, bus_write, bus_valid,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_write, bus_valid,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: msip register, 64-bit mtime/mtimecmp and mtip compare.
// Define CLINT_PRESCALE_EN to tick mtime once every PRESCALE clk cycles instead of every cycle.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    clint_timer_if.slave  bus,
    output logic          mtip,
    output logic          msip
);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_MTCMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTCMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("clint_timer: PRESCALE must be in 1..65535");
    end

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t      state_q, state_d;
    logic        sel, accept, wr_en, tick;
    logic [15:0] offset;
    logic [31:0] rd_mux, rdata_q;
    logic [63:0] mtime_q, mtimecmp_q;
    logic        msip_q, mtip_q;
    logic        unused_addr_bits;

    assign sel              = bus.bus_valid && (bus.bus_addr[31:16] == BASE_ADDR[31:16]);
    assign offset           = {bus.bus_addr[15:2], 2'b00};
    assign accept           = (state_q == IDLE) && sel;
    assign wr_en            = accept && bus.bus_write;
    assign unused_addr_bits = ^bus.bus_addr[1:0];

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_MSIP:     rd_mux = {31'b0, msip_q};
            OFF_MTCMP_LO: rd_mux = mtimecmp_q[31:0];
            OFF_MTCMP_HI: rd_mux = mtimecmp_q[63:32];
            OFF_MTIME_LO: rd_mux = mtime_q[31:0];
            OFF_MTIME_HI: rd_mux = mtime_q[63:32];
            default:      rd_mux = '0;
        endcase
    end

`ifdef CLINT_PRESCALE_EN
    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
    logic [15:0] prescale_q;

    assign tick = (prescale_q == PRESCALE_LAST);

    // Free-running divider; mtime writes deliberately leave its phase alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    prescale_q <= '0;
        else if (tick) prescale_q <= '0;
        else           prescale_q <= prescale_q + 16'd1;
    end
`else
    assign tick = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            // Holds the read value through ACK and returns to zero in IDLE.
            rdata_q <= (accept && !bus.bus_write) ? rd_mux : '0;
        end
    end

    // NOTE: the asynchronous reset reaches every architectural register, including the 64-bit timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q     <= 1'b0;
            mtimecmp_q <= '1;
            mtime_q    <= '0;
            mtip_q     <= 1'b0;
        end else begin
            if (wr_en && offset == OFF_MSIP)     msip_q            <= bus.bus_wdata[0];
            if (wr_en && offset == OFF_MTCMP_LO) mtimecmp_q[31:0]  <= bus.bus_wdata;
            if (wr_en && offset == OFF_MTCMP_HI) mtimecmp_q[63:32] <= bus.bus_wdata;

            // A write to either half beats the tick; the other half holds without carry.
            if (wr_en && offset == OFF_MTIME_LO)      mtime_q[31:0]  <= bus.bus_wdata;
            else if (wr_en && offset == OFF_MTIME_HI) mtime_q[63:32] <= bus.bus_wdata;
            else if (tick)                            mtime_q        <= mtime_q + 64'd1;

            mtip_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign bus.bus_ready = (state_q == ACK);
    assign bus.bus_rdata = rdata_q;
    assign mtip          = mtip_q;
    assign msip          = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed vector table, multi-cycle corner
// sequences and randomized bus traffic against an arithmetic timer model.
module tb_clint_timer;

    localparam int P = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mtip, msip;

    clint_timer_if bus_if ();

    clint_timer #(
        .BASE_ADDR(32'h0200_0000),
        .PRESCALE (P)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.slave),
        .mtip (mtip),
        .msip (msip)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Rising edges seen since the last reset release; edge index of the next edge.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Reference model: mtime is "value written at some edge plus ticks elapsed since".
    logic        m_msip;
    logic [63:0] m_cmp;
    logic [63:0] m_base;
    int          m_base_edge;

    function automatic logic [63:0] ticks(input int n);
`ifdef CLINT_PRESCALE_EN
        return 64'(n / P);
`else
        return 64'(n);
`endif
    endfunction

    // mtime value held just before rising edge n.
    function automatic logic [63:0] model_mtime(input int n);
        return m_base + (ticks(n) - ticks(m_base_edge));
    endfunction

    task automatic model_reset();
        m_msip      = 1'b0;
        m_cmp       = '1;
        m_base      = '0;
        m_base_edge = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int e);
        logic [15:0] off;
        logic [63:0] v;
        logic [31:0] exp_rd;
        int          waited;
        @(negedge clk);
        if (cyc > 0) check("mtip_model", 64'(mtip), 64'(model_mtime(cyc - 1) >= m_cmp));
        e      = cyc;
        off    = {addr[15:2], 2'b00};
        v      = model_mtime(e);
        exp_rd = '0;
        if (addr[31:16] == 16'h0200) begin
            case (off)
                16'h0000: exp_rd = {31'b0, m_msip};
                16'h4000: exp_rd = m_cmp[31:0];
                16'h4004: exp_rd = m_cmp[63:32];
                16'hBFF8: exp_rd = v[31:0];
                16'hBFFC: exp_rd = v[63:32];
                default:  exp_rd = '0;
            endcase
            if (wr) begin
                case (off)
                    16'h0000: m_msip        = wd[0];
                    16'h4000: m_cmp[31:0]   = wd;
                    16'h4004: m_cmp[63:32]  = wd;
                    16'hBFF8: begin v[31:0]  = wd; m_base = v; m_base_edge = e + 1; end
                    16'hBFFC: begin v[63:32] = wd; m_base = v; m_base_edge = e + 1; end
                    default: ;
                endcase
            end
        end
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wd;
        bus_if.bus_write = wr;
        bus_if.bus_valid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus_if.bus_ready && waited < 5);
        check("ready_latency", 64'(waited), 64'd1);
        rd = bus_if.bus_rdata;
        if (!wr) check("rdata_model", 64'(rd), 64'(exp_rd));
        bus_if.bus_valid = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", 64'(bus_if.bus_ready), 64'd0);
        check("msip_model", 64'(msip), 64'(m_msip));
    endtask

    task automatic txn_miss(input logic [31:0] addr);
        logic seen;
        @(negedge clk);
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = 32'hDEAD_BEEF;
        bus_if.bus_write = 1'b0;
        bus_if.bus_valid = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.bus_ready) seen = 1'b1;
        end
        check("miss_no_ready", 64'(seen), 64'd0);
        bus_if.bus_valid = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_msip;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] rd, rd1, rd2;
        int          e, e1, e2, bound;
        logic [15:0] offs[6];

        vecs[0]  = '{1'b1, 32'h0200_0000, 32'h0000_0001, 1'b0, 32'h0,         1'b1};
        vecs[1]  = '{1'b0, 32'h0200_0000, 32'h0,         1'b1, 32'h0000_0001, 1'b1};
        vecs[2]  = '{1'b1, 32'h0200_0000, 32'h0000_0000, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h0200_0000, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0200_1000, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 32'h0200_1000, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 32'h0200_0000, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 32'h0200_4004, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 32'h0200_4000, 32'h1234_5678, 1'b0, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h0200_4003, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
        vecs[10] = '{1'b0, 32'h0200_4004, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[11] = '{1'b1, 32'h0200_0002, 32'h0000_0003, 1'b0, 32'h0,         1'b1};
        vecs[12] = '{1'b0, 32'h0200_0000, 32'h0,         1'b1, 32'h0000_0001, 1'b1};
        vecs[13] = '{1'b1, 32'h0200_0000, 32'h0000_0000, 1'b0, 32'h0,         1'b0};

        offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1000};

        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;
        bus_if.bus_write = 1'b0;
        bus_if.bus_valid = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus_if.bus_ready), 64'd0);
        check("rst_rdata", 64'(bus_if.bus_rdata), 64'd0);
        check("rst_mtip",  64'(mtip), 64'd0);
        check("rst_msip",  64'(msip), 64'd0);
        rst_n = 1'b1;

        // First mtime read after reset release
        txn(1'b0, 32'h0200_BFF8, 32'h0, rd, e);
        check("first_read_msip", 64'(msip), 64'd0);
        check("first_read_mtip", 64'(mtip), 64'd0);

        // mtimecmp = 20 while mtime is still below it; mtip tracks mtime >= 20 cycle by cycle
        txn(1'b1, 32'h0200_4004, 32'h0, rd, e);
        txn(1'b1, 32'h0200_4000, 32'd20, rd, e);
        check("cmp_setup_below", 64'(model_mtime(cyc) < 64'd20), 64'd1);
        bound = 0;
        while (model_mtime(cyc - 1) < 64'd23 && bound < 400) begin
            @(negedge clk);
            bound++;
            check("mtip_rise", 64'(mtip), 64'(model_mtime(cyc - 1) >= 64'd20));
        end
        check("mtip_rise_timeout", 64'(bound < 400), 64'd1);
        check("mtip_high", 64'(mtip), 64'd1);
        txn(1'b1, 32'h0200_4000, 32'hFFFF_FFFF, rd, e);
        check("mtip_fall", 64'(mtip), 64'd0);

        // mtime wrap: all ones, then one tick later both halves read zero
        txn(1'b1, 32'h0200_BFFC, 32'hFFFF_FFFF, rd, e);
        txn(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFF, rd, e);
        repeat (12) @(negedge clk);
        txn(1'b0, 32'h0200_BFFC, 32'h0, rd, e);
        check("wrap_hi_zero", 64'(rd), 64'd0);
        txn(1'b0, 32'h0200_BFF8, 32'h0, rd, e);
        check("wrap_lo_small", 64'(rd < 32'd64), 64'd1);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, e);
            if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_msip", i), 64'(msip), 64'(vecs[i].exp_msip));
        end

        // Outside the window: never acknowledged
        txn_miss(32'h0300_0000);

        // mtime advance over exactly 100 clk cycles
        txn(1'b0, 32'h0200_BFF8, 32'h0, rd1, e1);
        repeat (97) @(negedge clk);
        txn(1'b0, 32'h0200_BFF8, 32'h0, rd2, e2);
        check("advance_span", 64'(e2 - e1), 64'd100);
`ifdef CLINT_PRESCALE_EN
        check("mtime_advance", 64'(rd2 - rd1), 64'd10);
`else
        check("mtime_advance", 64'(rd2 - rd1), 64'd100);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = {16'h0200, offs[$urandom_range(0, 5)]} | 32'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), a, $urandom, rd, e);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset asserted while ACK is showing
        @(negedge clk);
        bus_if.bus_addr  = 32'h0200_4000;
        bus_if.bus_wdata = 32'h0000_0005;
        bus_if.bus_write = 1'b1;
        bus_if.bus_valid = 1'b1;
        @(negedge clk);
        check("rst_ack_ready_before", 64'(bus_if.bus_ready), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack_ready", 64'(bus_if.bus_ready), 64'd0);
        check("rst_ack_rdata", 64'(bus_if.bus_rdata), 64'd0);
        check("rst_ack_mtip",  64'(mtip), 64'd0);
        bus_if.bus_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 32'h0200_4000, 32'h0, rd, e);
        check("rst_ack_cmp_lo", 64'(rd), 64'h0000_0000_FFFF_FFFF);
        txn(1'b0, 32'h0200_4004, 32'h0, rd, e);
        check("rst_ack_cmp_hi", 64'(rd), 64'h0000_0000_FFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0200_0000: bus window base, with bits [31:16] compared.
REQ-002 The block SHALL have parameter PRESCALE, default 10: clk cycles per mtime tick, used only when CLINT_PRESCALE_EN is defined, legal range 1..65535.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port bus_addr SHALL be an input, 32 bits: request byte address.
REQ-006 Port bus_wdata SHALL be an input, 32 bits: write data.
REQ-007 Port bus_write SHALL be an input, 1 bit: 1 = write, 0 = read.
REQ-008 Port bus_valid SHALL be an input, 1 bit: request present; the initiator holds it and the request fields stable until bus_ready.
REQ-009 Port bus_rdata SHALL be an output, 32 bits: read data, valid while bus_ready=1.
REQ-010 Port bus_ready SHALL be an output, 1 bit: one-cycle completion strobe.
REQ-011 Port mtip SHALL be an output, 1 bit: machine timer interrupt pending, level.
REQ-012 Port msip SHALL be an output, 1 bit: machine software interrupt pending, level.

Function
REQ-013 Select SHALL be asserted when bus_valid=1 and bus_addr[31:16]==BASE_ADDR[31:16]; the register offset is bus_addr[15:2]<<2, and bus_addr[1:0] is ignored.
REQ-014 The register map SHALL be: 0x0000 msip (bit0, other bits read 0); 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-015 The FSM SHALL have states IDLE and ACK; IDLE goes to ACK on select, and ACK goes to IDLE unconditionally.
REQ-016 On the IDLE->ACK edge, a write SHALL update the addressed register and a read SHALL register bus_rdata from the pre-update register value.
REQ-017 In ACK, bus_ready SHALL be 1 for exactly one cycle; in IDLE, bus_ready=0 and bus_rdata=0.
REQ-018 Fixed latency SHALL be: bus_ready asserts on the cycle after select is first sampled; a back-to-back request is accepted no earlier than the first IDLE cycle after ACK.
REQ-019 An unmapped offset inside the window SHALL still be acknowledged, with bus_rdata=0 and the write discarded.
REQ-020 An address outside the window SHALL NOT be acknowledged, and the FSM SHALL stay in IDLE.
REQ-021 mtime SHALL be a 64-bit counter that increments by 1 per tick and wraps from 2^64-1 to 0.
REQ-022 A bus write to either mtime half in the same cycle as a tick SHALL win: the written half takes wdata, and the other half holds without carry.
REQ-023 mtip SHALL be registered as (mtime >= mtimecmp), unsigned 64-bit, with one-cycle latency after any mtime or mtimecmp change.
REQ-024 msip SHALL be a direct copy of msip register bit0.
REQ-025 A write to one mtimecmp half SHALL leave the other half unchanged, and mtip SHALL follow the transient 64-bit value.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force: state=IDLE, bus_ready=0, bus_rdata=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip reg=0, mtip=0, prescale counter=0.
REQ-027 Reset asserted during ACK SHALL drop bus_ready immediately, and no write pending on that edge SHALL take effect.
REQ-028 The first possible acceptance SHALL be the first rising clk edge after rst_n rises.

Configuration
REQ-029 With CLINT_PRESCALE_EN defined, a 16-bit prescale counter SHALL count 0..PRESCALE-1, a tick SHALL occur when it equals PRESCALE-1 before it wraps to 0, and mtime writes SHALL NOT reset it.
REQ-030 With CLINT_PRESCALE_EN undefined, a tick SHALL occur every clk cycle, no prescale counter SHALL exist, and PRESCALE SHALL be ignored.

Verification
REQ-031 Bench scenario: reset release, then read 0xBFF8 -> bus_ready exactly 1 cycle after valid, rdata equal to the tick count so far, msip=0, mtip=0.
REQ-032 Bench scenario: write 0x0200_0000=32'h1 -> msip=1 on the cycle after ACK; write 0 -> msip=0; read returns 32'h1 then 32'h0.
REQ-033 Bench scenario: write mtimecmp hi=0 then lo=20 at mtime<20 -> mtip rises exactly one cycle after mtime reaches 20; write lo=32'hFFFF_FFFF -> mtip falls next cycle.
REQ-034 Bench scenario: write mtime lo=32'hFFFF_FFFF and hi=32'hFFFF_FFFF -> after one tick, mtime reads 0 in both halves, with no carry corruption.
REQ-035 Bench scenario: read 0x0200_1000 -> acked, rdata=0; read 0x0300_0000 -> no bus_ready for 10 cycles.
REQ-036 Bench scenario: with CLINT_PRESCALE_EN and PRESCALE=10, 100 cycles -> mtime advances by 10; rst_n pulsed low during ACK -> bus_ready=0 immediately and the written mtimecmp value stays all ones.
